sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed 8-bit, 16-deep `sync_fifo`. It adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and one-cycle overflow/underflow error pulses. A compile-time first-word-fall-through (FWFT) read mode is also available. It sits between a single-clock producer and consumer as the team's general-purpose buffering element.

---
 rtl/sync_fifo_param.sv | 107 ++++++++++
 tb/tb_sync_fifo_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered 1-cycle read.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr,
   input  logic                    rd,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_ok, rd_ok;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A read on a full FIFO frees a slot in the same edge, so the write is accepted too.
   assign rd_ok = rd && !empty;
   assign wr_ok = wr && (!full || rd);

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = wr && full && !rd;
      underflow_d = rd && empty;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) mem[wr_ptr_q] <= data_in;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = empty ? '0 : mem[rd_ptr_q];
`else
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   always_comb begin
      data_out_d = data_out_q;
      if (rd_ok) data_out_d = mem[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) data_out_q <= '0;
      else     data_out_q <= data_out_d;
   end

   assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: 8x16 instance plus a 32x4 instance for wrap-around.
// Expectations follow the registered-read mode unless SYNC_FIFO_FWFT_EN is defined.
module tb_sync_fifo_param;
   logic        clk = 1'b0;
   logic        rst, wr, rd;
   logic [7:0]  din;
   logic [31:0] din32;

   logic [7:0]  dout8;
   logic        full8, empty8, af8, ae8, ovf8, unf8;
   logic [4:0]  count8;
   logic [31:0] dout4;
   logic        full4, empty4, af4, ae4, ovf4, unf4;
   logic [2:0]  count4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_param u_dut8 (
      .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(din), .data_out(dout8),
      .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
      .count(count8), .overflow(ovf8), .underflow(unf8)
   );

   sync_fifo_param #(.DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(din32), .data_out(dout4),
      .full(full4), .empty(empty4), .almost_full(af4), .almost_empty(ae4),
      .count(count4), .overflow(ovf4), .underflow(unf4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, then sample 1 time unit after the rising edge.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      wr    = w;
      rd    = r;
      din   = d;
      din32 = {d, ~d, d, ~d};
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_b;
      rst = 1'b1;
      step(1'b1, 1'b1, 8'hFF);
      step(1'b1, 1'b1, 8'hFF);
      check("rst_count", count8, 0);
      check("rst_empty", empty8, 1);
      check("rst_full", full8, 0);
      check("rst_ae", ae8, 1);
      check("rst_af", af8, 0);
      check("rst_dout", dout8, 0);
      check("rst_ovf", ovf8, 0);
      check("rst_unf", unf8, 0);
      rst = 1'b0;

      // Fill with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0, 8'(i));
         check("fill_count", count8, i);
         check("fill_af", af8, 32'(i >= 14));
         check("fill_full", full8, 32'(i == 16));
         check("fill_ae", ae8, 32'(i <= 2));
`ifdef SYNC_FIFO_FWFT_EN
         check("fill_dout_fwft", dout8, 8'h01);
`else
         check("fill_dout", dout8, 0);
`endif
      end
      check("d4_full", full4, 1);
      check("d4_count", count4, 4);

      step(1'b1, 1'b0, 8'hAA);
      check("ovf_pulse", ovf8, 1);
      check("ovf_count", count8, 16);
      step(1'b0, 1'b0, 8'h00);
      check("ovf_clear", ovf8, 0);

      // Simultaneous write+read while full: 0x01 leaves, 0x55 enters
      step(1'b1, 1'b1, 8'h55);
      check("full_rw_count", count8, 16);
      check("full_rw_ovf", ovf8, 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("full_rw_head", dout8, 8'h02);
`else
      check("full_rw_dout", dout8, 8'h01);
`endif

      // Drain: 0x02..0x10 then 0x55
      for (int k = 0; k < 16; k++) begin
         exp_b = (k < 15) ? 8'(k + 2) : 8'h55;
`ifdef SYNC_FIFO_FWFT_EN
         check("drain_head", dout8, exp_b);
`endif
         step(1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
         check("drain_dout", dout8, exp_b);
`endif
         check("drain_count", count8, 15 - k);
         check("drain_ae", ae8, 32'((15 - k) <= 2));
         check("drain_empty", empty8, 32'(k == 15));
      end
      check("d4_empty", empty4, 1);

      step(1'b0, 1'b1, 8'h00);
      check("unf_pulse", unf8, 1);
      check("unf_count", count8, 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("unf_dout_fwft", dout8, 0);
`else
      check("unf_dout_hold", dout8, 8'h55);
`endif
      step(1'b0, 1'b0, 8'h00);
      check("unf_clear", unf8, 0);

      // Simultaneous write+read while empty: write wins, read rejected
      step(1'b1, 1'b1, 8'h66);
      check("empty_rw_unf", unf8, 1);
      check("empty_rw_count", count8, 1);
      check("empty_rw_empty", empty8, 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("empty_rw_head", dout8, 8'h66);
      step(1'b0, 1'b1, 8'h00);
      check("fwft_pop_dout", dout8, 0);
      check("fwft_pop_empty", empty8, 1);
`else
      check("empty_rw_dout", dout8, 8'h55);
      step(1'b0, 1'b1, 8'h00);
      check("empty_rw_read", dout8, 8'h66);
      check("empty_rw_drained", empty8, 1);
`endif
      check("d4_pre_wrap_empty", empty4, 1);

      // Wrap-around on both instances with an incrementing pattern
      for (int v = 0; v < 40; v++) begin
         exp_b = 8'(8'h80 + v);
         step(1'b1, 1'b0, exp_b);
         check("wrap_count8", count8, 1);
         check("wrap_count4", count4, 1);
`ifdef SYNC_FIFO_FWFT_EN
         check("wrap_head8", dout8, exp_b);
         check("wrap_head4", dout4, {exp_b, ~exp_b, exp_b, ~exp_b});
`endif
         step(1'b0, 1'b1, 8'h00);
         check("wrap_empty8", count8, 0);
`ifndef SYNC_FIFO_FWFT_EN
         check("wrap_dout8", dout8, exp_b);
         check("wrap_dout4", dout4, {exp_b, ~exp_b, exp_b, ~exp_b});
`endif
      end

      // Reset mid-fill at count 7
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
      check("mid_count", count8, 7);
      rst = 1'b1;
      step(1'b1, 1'b1, 8'h99);
      check("mid_rst_count", count8, 0);
      check("mid_rst_empty", empty8, 1);
      check("mid_rst_unf", unf8, 0);
      check("mid_rst_dout", dout8, 0);
      rst = 1'b0;
      step(1'b0, 1'b0, 8'h00);
      check("post_rst_count", count8, 0);
      step(1'b1, 1'b0, 8'h42);
`ifdef SYNC_FIFO_FWFT_EN
      check("post_rst_head", dout8, 8'h42);
      step(1'b0, 1'b1, 8'h00);
`else
      step(1'b0, 1'b1, 8'h00);
      check("post_rst_read", dout8, 8'h42);
`endif
      check("post_rst_empty", empty8, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
